// File: rtl/pep_load_blwe_mc_if.sv
// rtl/pep_load_blwe_mc_if.sv - bus bundle for the BLWE load block
//
// Groups the command, regfile read and write-back streams of pep_load_blwe_mc.
//   cmd_*      : load command handshake (rid, pid, last-of-batch)
//   rd_req_*   : regfile read request handshake
//   rd_data_*  : regfile read data return (per-coefficient avail, last word)
//   wr_*       : registered write-back, split into SUBW_NB sub-words
// Modport slave is the load block's view; master is the surrounding logic.

interface pep_load_blwe_mc_if #(
  parameter int COEF_NB = 8,
  parameter int SUBW_NB = 2,
  parameter int MOD_W   = 64,
  parameter int PID_W   = 6,
  parameter int RID_W   = 6
);
  logic                     cmd_vld;
  logic                     cmd_rdy;
  logic [RID_W-1:0]         cmd_rid;
  logic [PID_W-1:0]         cmd_pid;
  logic                     cmd_last;

  logic                     rd_req_vld;
  logic                     rd_req_rdy;
  logic [RID_W-1:0]         rd_req_rid;

  logic [COEF_NB-1:0]       rd_data_avail;
  logic [COEF_NB*MOD_W-1:0] rd_data;
  logic                     rd_last_word;

  logic [SUBW_NB-1:0]       wr_en;
  logic [SUBW_NB*PID_W-1:0] wr_pid;
  logic [COEF_NB*MOD_W-1:0] wr_data;
  logic [SUBW_NB-1:0]       wr_pbs_last;

  modport master (
    output cmd_vld, cmd_rid, cmd_pid, cmd_last,
    input  cmd_rdy,
    input  rd_req_vld, rd_req_rid,
    output rd_req_rdy,
    output rd_data_avail, rd_data, rd_last_word,
    input  wr_en, wr_pid, wr_data, wr_pbs_last
  );

  modport slave (
    input  cmd_vld, cmd_rid, cmd_pid, cmd_last,
    output cmd_rdy,
    output rd_req_vld, rd_req_rid,
    input  rd_req_rdy,
    input  rd_data_avail, rd_data, rd_last_word,
    output wr_en, wr_pid, wr_data, wr_pbs_last
  );
endinterface

// File: rtl/pep_load_blwe_mc.sv
// rtl/pep_load_blwe_mc.sv - BLWE load: command queue, regfile read issue, tagged write-back
//
// Ports:
//   clk, s_rst : clock, synchronous active-high reset
//   bus        : pep_load_blwe_mc_if.slave (cmd_*, rd_req_*, rd_data_*, wr_*)
//   done       : one-cycle pulse per completed BLWE, aligned with its final wr_en
//   busy       : commands queued, reads in flight, or a write still in the output register
//   err        : sticky [0] data with nothing in flight, [1] partial rd_data_avail
//   rcp_cycles : cycles with reads in flight, saturating (only with PEP_LDB_MC_RCP_CNT_EN)

module pep_load_blwe_mc #(
  parameter int COEF_NB   = 8,
  parameter int SUBW_NB   = 2,
  parameter int MOD_W     = 64,
  parameter int PID_W     = 6,
  parameter int RID_W     = 6,
  parameter int CMD_DEPTH = 4,
  parameter int MAX_OUTST = 4
) (
  input  logic              clk,
  input  logic              s_rst,
  pep_load_blwe_mc_if.slave bus,
  output logic              done,
  output logic              busy,
  output logic [1:0]        err
`ifdef PEP_LDB_MC_RCP_CNT_EN
  ,
  output logic [31:0]       rcp_cycles
`endif
);

  localparam int CA = $clog2(CMD_DEPTH);
  localparam int IA = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int OW = $clog2(MAX_OUTST) + 1;
  localparam int GW = COEF_NB / SUBW_NB;
  localparam logic [OW-1:0] OUTST_MAX = OW'(MAX_OUTST);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_STALL} state_t;
  state_t state, state_nxt;

  logic [RID_W-1:0] cq_rid  [CMD_DEPTH];
  logic [PID_W-1:0] cq_pid  [CMD_DEPTH];
  logic             cq_last [CMD_DEPTH];
  logic [CA:0]      cq_wp, cq_rp, cq_cnt, cq_cnt_nxt;
  logic             cq_empty, cq_full, cq_push, cq_pop;

  // In-flight occupancy always equals outst, so its pointers need no wrap bit.
  logic [PID_W-1:0] if_pid  [2**IA];
  logic             if_last [2**IA];
  logic [IA-1:0]    if_wp, if_rp;
  logic [OW-1:0]    outst, outst_nxt;

  logic             req_vld, rd_acc;
  logic             beat_any, beat_ok, last_beat, head_last;
  logic [PID_W-1:0] head_pid;
  logic [SUBW_NB-1:0] grp_en;

  logic [SUBW_NB-1:0]       wr_en_q, wr_pbs_last_q;
  logic [SUBW_NB*PID_W-1:0] wr_pid_q;
  logic [COEF_NB*MOD_W-1:0] wr_data_q;
  logic                     done_q;
  logic [1:0]               err_q;

  // Command FIFO; a full FIFO still takes a push when the head pops this cycle.
  assign cq_empty   = (cq_wp == cq_rp);
  assign cq_full    = (cq_wp[CA] != cq_rp[CA]) && (cq_wp[CA-1:0] == cq_rp[CA-1:0]);
  assign cq_cnt     = cq_wp - cq_rp;
  assign rd_acc     = req_vld && bus.rd_req_rdy;
  assign cq_pop     = rd_acc;
  assign bus.cmd_rdy = !s_rst && (!cq_full || cq_pop);
  assign cq_push    = bus.cmd_vld && bus.cmd_rdy;
  assign cq_cnt_nxt = cq_cnt + (CA+1)'(cq_push) - (CA+1)'(cq_pop);

  always_ff @(posedge clk) begin
    if (s_rst) begin
      cq_wp <= '0;
      cq_rp <= '0;
    end else begin
      if (cq_push) cq_wp <= cq_wp + 1'b1;
      if (cq_pop)  cq_rp <= cq_rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (cq_push) begin
      cq_rid[cq_wp[CA-1:0]]  <= bus.cmd_rid;
      cq_pid[cq_wp[CA-1:0]]  <= bus.cmd_pid;
      cq_last[cq_wp[CA-1:0]] <= bus.cmd_last;
    end
  end

  // Return beats; anything arriving with nothing in flight is dropped.
  assign beat_any  = |bus.rd_data_avail;
  assign beat_ok   = beat_any && (outst != '0);
  assign last_beat = beat_ok && bus.rd_last_word && bus.rd_data_avail[0];
  assign head_pid  = if_pid[if_rp];
  assign head_last = if_last[if_rp];
  assign outst_nxt = outst + OW'(rd_acc) - OW'(last_beat);

  always_ff @(posedge clk) begin
    if (s_rst) begin
      if_wp <= '0;
      if_rp <= '0;
      outst <= '0;
    end else begin
      if (rd_acc)    if_wp <= if_wp + 1'b1;
      if (last_beat) if_rp <= if_rp + 1'b1;
      outst <= outst_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_acc) begin
      if_pid[if_wp]  <= cq_pid[cq_rp[CA-1:0]];
      if_last[if_wp] <= cq_last[cq_rp[CA-1:0]];
    end
  end

  // Issue FSM. Transitions look at next-cycle counts so a freed slot is
  // reused on the cycle right after the releasing beat.
  always_ff @(posedge clk) begin
    if (s_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (cq_cnt_nxt != '0) state_nxt = ST_REQ;
      ST_REQ: begin
        if (outst_nxt == OUTST_MAX)  state_nxt = ST_STALL;
        else if (cq_cnt_nxt == '0)   state_nxt = ST_IDLE;
      end
      ST_STALL: if (outst_nxt < OUTST_MAX) state_nxt = ST_REQ;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_vld = !s_rst && (state == ST_REQ) && !cq_empty && (outst < OUTST_MAX);
  end

  assign bus.rd_req_vld = req_vld;
  assign bus.rd_req_rid = cq_rid[cq_rp[CA-1:0]];

  always_comb begin
    grp_en = '0;
    for (int s = 0; s < SUBW_NB; s++) grp_en[s] = |bus.rd_data_avail[s*GW +: GW];
  end

  // Write-back register: one cycle after the beat.
  always_ff @(posedge clk) begin
    if (s_rst) begin
      wr_en_q       <= '0;
      wr_pbs_last_q <= '0;
      done_q        <= 1'b0;
      err_q         <= '0;
    end else begin
      wr_en_q       <= beat_ok ? grp_en : '0;
      wr_pbs_last_q <= {SUBW_NB{last_beat && head_last}};
      done_q        <= last_beat;
      err_q         <= err_q | {beat_any && !(&bus.rd_data_avail),
                                beat_any && (outst == '0)};
    end
  end

  always_ff @(posedge clk) begin
    if (beat_ok) begin
      wr_pid_q  <= {SUBW_NB{head_pid}};
      wr_data_q <= bus.rd_data;
    end
  end

  assign bus.wr_en       = s_rst ? '0 : wr_en_q;
  assign bus.wr_pbs_last = s_rst ? '0 : wr_pbs_last_q;
  assign bus.wr_pid      = wr_pid_q;
  assign bus.wr_data     = wr_data_q;
  assign done            = !s_rst && done_q;
  assign err             = s_rst ? 2'b00 : err_q;
  assign busy            = !s_rst && (!cq_empty || (outst != '0) || (|wr_en_q));

`ifdef PEP_LDB_MC_RCP_CNT_EN
  logic [31:0] rcp_q;
  always_ff @(posedge clk) begin
    if (s_rst)                                rcp_q <= '0;
    else if ((outst != '0) && (rcp_q != '1))  rcp_q <= rcp_q + 1'b1;
  end
  assign rcp_cycles = rcp_q;
`endif

endmodule

// File: doc/pep_load_blwe_mc.md
PEP_LOAD_BLWE_MC -- requirements
Module: pep_load_blwe_mc

Interface
- REQ-001: Parameter COEF_NB, default 8: coefficients per regfile read beat.
- REQ-002: Parameter SUBW_NB, default 2: output write sub-words; COEF_NB SHALL be a multiple of SUBW_NB.
- REQ-003: Parameter MOD_W, default 64: coefficient width.
- REQ-004: Parameter PID_W / RID_W, default 6 / 6: PBS id and regfile id widths.
- REQ-005: Parameter CMD_DEPTH, default 4 (power of 2, >=2): command FIFO depth.
- REQ-006: Parameter MAX_OUTST, default 4 (power of 2, >=1): maximum in-flight regfile reads.
- REQ-007: The block has one clock. Reset is synchronous and active-high. The ports are as follows.
- REQ-008: clk  in  1  clock.
- REQ-009: s_rst  in  1  synchronous reset, active high.
- REQ-010: cmd_vld/cmd_rdy  in/out  1/1  load command handshake.
- REQ-011: cmd_rid, cmd_pid, cmd_last  in  RID_W, PID_W, 1  source register, PBS id, last-of-batch flag.
- REQ-012: rd_req_vld/rd_req_rdy  out/in  1/1  regfile read request handshake.
- REQ-013: rd_req_rid  out  RID_W  register to read.
- REQ-014: rd_data_avail  in  COEF_NB  per-coefficient data valid.
- REQ-015: rd_data  in  COEF_NB*MOD_W  read data.
- REQ-016: rd_last_word  in  1  last beat of the current BLWE, qualified by rd_data_avail[0].
- REQ-017: wr_en  out  SUBW_NB  per-sub-word write enable.
- REQ-018: wr_pid  out  SUBW_NB*PID_W  PBS id per sub-word.
- REQ-019: wr_data  out  COEF_NB*MOD_W  coefficient data, split into SUBW_NB groups of COEF_NB/SUBW_NB coefficients.
- REQ-020: wr_pbs_last  out  SUBW_NB  last-of-batch marker.
- REQ-021: done  out  1  one-cycle pulse per completed BLWE.
- REQ-022: busy  out  1  high while commands are queued or in flight.
- REQ-023: err  out  2  sticky errors: [0] unexpected data, [1] partial avail.

Function
- REQ-024: The command FIFO SHALL have CMD_DEPTH entries; cmd_rdy = !full, and a push occurs on cmd_vld&&cmd_rdy.
- REQ-025: The issue FSM SHALL have three states.
  - IDLE -> REQ when the FIFO is non-empty.
  - REQ -> STALL when outst==MAX_OUTST.
  - REQ -> IDLE when the FIFO is empty after a pop.
  - STALL -> REQ when outst<MAX_OUTST.
- REQ-026: rd_req_vld SHALL be high only in REQ with a non-empty FIFO and outst<MAX_OUTST; rd_req_rid = FIFO head rid; vld SHALL hold stable until rdy.
- REQ-027: On rd_req_vld&&rd_req_rdy, the block SHALL pop the command FIFO and push {pid,last} into the in-flight FIFO (depth MAX_OUTST).
- REQ-028: The outstanding counter outst SHALL be incremented on request accept and decremented on a beat with rd_last_word&&rd_data_avail[0]; a simultaneous accept and last beat SHALL leave it unchanged.
- REQ-029: Data SHALL return in request order; each beat SHALL be tagged with the pid at the in-flight FIFO head.
- REQ-030: Write outputs SHALL be registered with latency exactly 1 cycle.
  - wr_en[s] = avail of group s.
  - wr_pid[s] = head pid.
  - wr_pbs_last[s] = rd_last_word && head.last.
- REQ-031: The in-flight FIFO SHALL pop on the last beat; done SHALL pulse 1 cycle after that beat, aligned with the final wr_en.
- REQ-032: busy = command FIFO non-empty || outst!=0 || a write is pending in the output register.
- REQ-033: Beats with rd_data_avail!=0 while outst==0 SHALL be dropped (no wr_en) and SHALL set err[0].
- REQ-034: rd_data_avail neither all-zero nor all-one SHALL set err[1]; those data are still written per group.
- REQ-035: The command FIFO SHALL accept a push while full only if a pop occurs in the same cycle; otherwise cmd_rdy=0 and no data is lost.
- REQ-036: Pointers SHALL wrap modulo depth; full/empty SHALL be distinguished by an extra pointer bit.

Reset
- REQ-037: While s_rst is high, the FSM SHALL go to IDLE, both FIFOs SHALL empty, outst=0, and cmd_rdy, rd_req_vld, wr_en, wr_pbs_last, done, busy and err SHALL all be 0.
- REQ-038: A reset mid-transfer SHALL discard in-flight state; beats arriving after reset release SHALL set err[0].

Configuration
- REQ-039: Macro PEP_LDB_MC_RCP_CNT_EN SHALL control an extra output rcp_cycles[31:0].
  - Defined: rcp_cycles counts cycles with outst!=0, saturates at 2^32-1, and clears on reset.
  - Not defined: rcp_cycles is absent, with no counter logic.

Verification
- REQ-040: Single cmd rid=3, pid=5, last=1, rdy always 1, 4 beats -> rd_req_rid=3; 4x wr_en=all-ones with pid=5; wr_pbs_last only on beat 4; done 1 cycle after beat 4; busy then 0.
- REQ-041: 6 cmds pushed back-to-back, CMD_DEPTH=4, rd_req_rdy=0 -> cmd_rdy low after 4 pushes; release rdy -> all 6 requested in order.
- REQ-042: rd_req_rdy=1, no data returned, MAX_OUTST=4 -> exactly 4 requests, FSM in STALL; one last beat -> a 5th request is issued the next cycle.
- REQ-043: Last beat coinciding with a request accept -> outst unchanged; wr_pid follows the head pid and is not corrupted.
- REQ-044: Avail=0x0F with COEF_NB=8, SUBW_NB=2 -> wr_en=2'b01 and err[1] set; avail with outst=0 -> no wr_en and err[0] set.
- REQ-045: s_rst asserted mid-BLWE -> all outputs 0 the next cycle; a new cmd after release completes normally.
